// File: rtl/sample_buffer.sv
// Per-channel circular sample history with in_flag re-timing, x(n-k) reads and zero-run sleep detection.
// Optional build macro SAMPLE_BUFFER_PEAK_EN adds running |peak| outputs per channel.
module sample_buffer #(
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter int SLEEP_CNT = 800,
  parameter int CW        = 10
) (
  input  logic          Sclk,
  input  logic          Clear,
  input  logic          in_flag,
  input  logic [15:0]   dataL,
  input  logic [15:0]   dataR,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_offset,
  output logic [15:0]   rdataL,
  output logic [15:0]   rdataR,
  output logic          rd_valid,
  output logic          new_sample,
  output logic [AW:0]   sample_count,
`ifdef SAMPLE_BUFFER_PEAK_EN
  output logic [15:0]   peakL,
  output logic [15:0]   peakR,
`endif
  output logic          sleep_flag
);

  logic [15:0] mem_l_q [DEPTH];
  logic [15:0] mem_r_q [DEPTH];

  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] zcnt_q, zcnt_d;
  logic          sleep_q, sleep_d;
  logic          new_sample_q, new_sample_d;
  logic          rd_valid_q, rd_valid_d;
  logic [15:0]   rdata_l_q, rdata_l_d, rdata_r_q, rdata_r_d;

  logic          wr_go;
  logic          zero_pair;
  logic [AW-1:0] newest;
  logic [AW-1:0] rd_addr;

  always_comb begin
    s1_d = in_flag;
    s2_d = s1_q;
    s3_d = s2_q;
    // Only the rising edge of the re-timed strobe writes, so a held in_flag writes once.
    wr_go     = s2_q & ~s3_q;
    zero_pair = (dataL == 16'h0000) && (dataR == 16'h0000);

    wr_ptr_d     = wr_go ? wr_ptr_q + AW'(1) : wr_ptr_q;
    new_sample_d = wr_go;

    count_d = count_q;
    if (wr_go && (count_q != (AW+1)'(DEPTH))) begin
      count_d = count_q + (AW+1)'(1);
    end

    zcnt_d  = zcnt_q;
    sleep_d = sleep_q;
    if (wr_go) begin
      if (zero_pair) begin
        if (zcnt_q != CW'(SLEEP_CNT)) begin
          zcnt_d = zcnt_q + CW'(1);
        end
        if (zcnt_d == CW'(SLEEP_CNT)) begin
          sleep_d = 1'b1;
        end
      end else begin
        zcnt_d  = '0;
        sleep_d = 1'b0;
      end
    end

    // Reads address from pre-write state; unwritten entries are still zero from reset.
    newest     = wr_ptr_q - AW'(1);
    rd_addr    = newest - rd_offset;
    rd_valid_d = rd_en;
    rdata_l_d  = rd_en ? mem_l_q[rd_addr] : rdata_l_q;
    rdata_r_d  = rd_en ? mem_r_q[rd_addr] : rdata_r_q;
  end

  always_ff @(posedge Sclk) begin
    if (!Clear) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      s3_q         <= 1'b1;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      zcnt_q       <= '0;
      sleep_q      <= 1'b0;
      new_sample_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rdata_l_q    <= '0;
      rdata_r_q    <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      zcnt_q       <= zcnt_d;
      sleep_q      <= sleep_d;
      new_sample_q <= new_sample_d;
      rd_valid_q   <= rd_valid_d;
      rdata_l_q    <= rdata_l_d;
      rdata_r_q    <= rdata_r_d;
    end
  end

  always_ff @(posedge Sclk) begin
    if (!Clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_l_q[i] <= '0;
        mem_r_q[i] <= '0;
      end
    end else if (wr_go) begin
      mem_l_q[wr_ptr_q] <= dataL;
      mem_r_q[wr_ptr_q] <= dataR;
    end
  end

  assign rdataL       = rdata_l_q;
  assign rdataR       = rdata_r_q;
  assign rd_valid     = rd_valid_q;
  assign new_sample   = new_sample_q;
  assign sample_count = count_q;
  assign sleep_flag   = sleep_q;

`ifdef SAMPLE_BUFFER_PEAK_EN
  logic [15:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic [15:0] abs_l, abs_r, base_l, base_r;
  logic        wake;

  function automatic logic [15:0] abs_sat(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'h8000) begin
      r = 16'h7fff;
    end else if (v[15]) begin
      r = 16'h0000 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  always_comb begin
    abs_l    = abs_sat(dataL);
    abs_r    = abs_sat(dataR);
    // A non-zero write while asleep starts a fresh peak window.
    wake     = sleep_q & ~zero_pair;
    base_l   = wake ? 16'h0000 : peak_l_q;
    base_r   = wake ? 16'h0000 : peak_r_q;
    peak_l_d = peak_l_q;
    peak_r_d = peak_r_q;
    if (wr_go) begin
      peak_l_d = (abs_l > base_l) ? abs_l : base_l;
      peak_r_d = (abs_r > base_r) ? abs_r : base_r;
    end
  end

  always_ff @(posedge Sclk) begin
    if (!Clear) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peakL = peak_l_q;
  assign peakR = peak_r_q;
`endif

endmodule

// File: tb/tb_sample_buffer.sv
// Directed bench for sample_buffer: read responses go through an expected-value queue checked by a monitor.
module tb_sample_buffer;

  logic        Sclk = 1'b0;
  logic        Clear;
  logic        in_flag;
  logic [15:0] dataL, dataR;
  logic        rd_en;
  logic [7:0]  rd_offset;
  logic [15:0] rdataL, rdataR;
  logic        rd_valid;
  logic        new_sample;
  logic [8:0]  sample_count;
  logic        sleep_flag;
`ifdef SAMPLE_BUFFER_PEAK_EN
  logic [15:0] peakL, peakR;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  sample_buffer dut (
    .Sclk(Sclk), .Clear(Clear), .in_flag(in_flag),
    .dataL(dataL), .dataR(dataR),
    .rd_en(rd_en), .rd_offset(rd_offset),
    .rdataL(rdataL), .rdataR(rdataR), .rd_valid(rd_valid),
    .new_sample(new_sample), .sample_count(sample_count),
`ifdef SAMPLE_BUFFER_PEAK_EN
    .peakL(peakL), .peakR(peakR),
`endif
    .sleep_flag(sleep_flag)
  );

  always #5 Sclk = ~Sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid pulse consumes one expected {rdataL, rdataR}.
  always @(negedge Sclk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected act=%h req=none", {rdataL, rdataR});
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({rdataL, rdataR} !== e) begin
          errors++;
          $display("FAIL rd_data act=%h req=%h", {rdataL, rdataR}, e);
        end
      end
    end
  end

  // Called at a negedge with the synchronizer settled low.
  task automatic write_pair(input logic [15:0] l, input logic [15:0] r,
                            input bit rd_same, input logic [15:0] el, input logic [15:0] er);
    dataL   = l;
    dataR   = r;
    in_flag = 1'b1;
    @(negedge Sclk);
    @(negedge Sclk);
    if (rd_same) begin
      rd_en     = 1'b1;
      rd_offset = 8'd0;
      exp_q.push_back({el, er});
    end
    @(negedge Sclk);
    rd_en = 1'b0;
    chk("new_sample_pulse", {31'd0, new_sample}, 32'd1);
    in_flag = 1'b0;
    @(negedge Sclk);
    chk("new_sample_one_cycle", {31'd0, new_sample}, 32'd0);
    @(negedge Sclk);
    @(negedge Sclk);
  endtask

  task automatic rd(input logic [7:0] off, input logic [15:0] el, input logic [15:0] er);
    rd_en     = 1'b1;
    rd_offset = off;
    exp_q.push_back({el, er});
    @(negedge Sclk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    Clear   = 1'b0;
    in_flag = 1'b0;
    rd_en   = 1'b0;
    repeat (2) @(negedge Sclk);
    Clear = 1'b1;
    repeat (4) @(negedge Sclk);
  endtask

  initial begin
    Clear     = 1'b0;
    in_flag   = 1'b1;
    dataL     = 16'h0000;
    dataR     = 16'h0000;
    rd_en     = 1'b0;
    rd_offset = 8'd0;
    repeat (3) @(negedge Sclk);

    // Reset state, then release with in_flag already high.
    chk("rst_rdataL", {16'd0, rdataL}, 32'd0);
    chk("rst_rdataR", {16'd0, rdataR}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_new_sample", {31'd0, new_sample}, 32'd0);
    chk("rst_sample_count", {23'd0, sample_count}, 32'd0);
    chk("rst_sleep_flag", {31'd0, sleep_flag}, 32'd0);
    Clear = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Sclk);
      chk("no_write_after_rst", {31'd0, new_sample}, 32'd0);
    end
    in_flag = 1'b0;
    repeat (4) @(negedge Sclk);
    chk("count_after_held_flag", {23'd0, sample_count}, 32'd0);

    // Single write and newest read; rdata holds afterwards.
    write_pair(16'h1234, 16'hABCD, 1'b0, 16'h0, 16'h0);
    chk("count_one", {23'd0, sample_count}, 32'd1);
    rd(8'd0, 16'h1234, 16'hABCD);
    repeat (2) @(negedge Sclk);
    chk("rdataL_hold", {16'd0, rdataL}, 32'h1234);
    chk("rd_valid_idle", {31'd0, rd_valid}, 32'd0);

    // Three samples, out-of-range offset, read on the write edge.
    write_pair(16'h1111, 16'h2222, 1'b0, 16'h0, 16'h0);
    write_pair(16'h3333, 16'h4444, 1'b0, 16'h0, 16'h0);
    chk("count_three", {23'd0, sample_count}, 32'd3);
    rd(8'd5, 16'h0000, 16'h0000);
    rd(8'd2, 16'h1234, 16'hABCD);
    write_pair(16'h5555, 16'h6666, 1'b1, 16'h3333, 16'h4444);
    rd(8'd0, 16'h5555, 16'h6666);
    rd(8'd3, 16'h1234, 16'hABCD);

    // 300 writes: L=i, R=~i; wrap-around and count saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      write_pair(16'(i), ~16'(i), 1'b0, 16'h0, 16'h0);
    end
    chk("count_saturated", {23'd0, sample_count}, 32'd256);
    rd(8'd0,   16'h012B, 16'hFED4);
    rd(8'd1,   16'h012A, 16'hFED5);
    rd(8'd255, 16'h002C, 16'hFFD3);

    // Clear one cycle after an in_flag rise: no write, buffer cleared.
    dataL   = 16'hBEEF;
    dataR   = 16'hBEEF;
    in_flag = 1'b1;
    @(negedge Sclk);
    Clear = 1'b0;
    @(negedge Sclk);
    chk("midrst_no_pulse0", {31'd0, new_sample}, 32'd0);
    @(negedge Sclk);
    Clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Sclk);
      chk("midrst_no_pulse", {31'd0, new_sample}, 32'd0);
    end
    in_flag = 1'b0;
    repeat (4) @(negedge Sclk);
    chk("midrst_count", {23'd0, sample_count}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      rd(8'(i), 16'h0000, 16'h0000);
    end
    write_pair(16'h0A0A, 16'h0B0B, 1'b0, 16'h0, 16'h0);
    rd(8'd0, 16'h0A0A, 16'h0B0B);
    rd(8'd1, 16'h0000, 16'h0000);

    // Sleep detection.
    do_reset();
    for (int i = 0; i < 799; i++) begin
      write_pair(16'h0000, 16'h0000, 1'b0, 16'h0, 16'h0);
    end
    chk("sleep_799", {31'd0, sleep_flag}, 32'd0);
    write_pair(16'h0000, 16'h0000, 1'b0, 16'h0, 16'h0);
    chk("sleep_800", {31'd0, sleep_flag}, 32'd1);
    chk("count_after_800", {23'd0, sample_count}, 32'd256);
    write_pair(16'h0000, 16'h0001, 1'b0, 16'h0, 16'h0);
    chk("wake_nonzero", {31'd0, sleep_flag}, 32'd0);
    rd(8'd0, 16'h0000, 16'h0001);
    for (int i = 0; i < 799; i++) begin
      write_pair(16'h0000, 16'h0000, 1'b0, 16'h0, 16'h0);
    end
    chk("sleep_restart_799", {31'd0, sleep_flag}, 32'd0);
    write_pair(16'h0000, 16'h0000, 1'b0, 16'h0, 16'h0);
    chk("sleep_restart_800", {31'd0, sleep_flag}, 32'd1);

    repeat (4) @(negedge Sclk);
    chk("reads_all_returned", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
